// File: rtl/arc4_pkg.sv
// Shared ARC4 definitions: byte type, PRGA state encoding and printable-range defaults.
package arc4_pkg;

    typedef logic [7:0] byte_t;

    localparam byte_t PRINT_LO_DEFAULT = 8'h20;
    localparam byte_t PRINT_HI_DEFAULT = 8'h7E;

    typedef enum logic [3:0] {
        IDLE,
        RD_LEN,
        WT_LEN,
        WR_LEN,
        RD_SI,
        WT_SI,
        RD_SJ,
        WT_SJ,
        WR_SI,
        WR_SJ,
        RD_PAD,
        WT_PAD,
        WR_PT
    } prga_state_t;

endpackage

// File: rtl/prga_decrypt.sv
// ARC4 pseudo-random generation stage. Consumes a length-prefixed ciphertext,
// swaps S in place while generating keystream, writes length-prefixed plaintext
// and reports whether every plaintext byte fell inside the printable range.
// Memory addresses are combinational from state; each read is held through a
// wait state so the 1-cycle-latency memories present data on the capture cycle.
module prga_decrypt
    import arc4_pkg::*;
#(
    parameter byte_t PRINT_LO = PRINT_LO_DEFAULT,
    parameter byte_t PRINT_HI = PRINT_HI_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic       rdy,
    output logic       printable,
    output logic [7:0] s_addr,
    input  logic [7:0] s_rddata,
    output logic [7:0] s_wrdata,
    output logic       s_wren,
    output logic [7:0] ct_addr,
    input  logic [7:0] ct_rddata,
    output logic [7:0] pt_addr,
    output logic [7:0] pt_wrdata,
    output logic       pt_wren
);

    prga_state_t state;
    prga_state_t next_state;

    byte_t       i;
    byte_t       j;
    logic [8:0]  k;
    byte_t       len;
    byte_t       si;
    byte_t       sj;
    byte_t       ct;

    byte_t       pt_byte;
    logic        last_byte;

    assign pt_byte   = s_rddata ^ ct;
    assign last_byte = (k == {1'b0, len});
    assign rdy       = (state == IDLE);

    // State register plus the datapath registers captured in specific states.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            i         <= '0;
            j         <= '0;
            k         <= '0;
            len       <= '0;
            si        <= '0;
            sj        <= '0;
            ct        <= '0;
            printable <= 1'b0;
        end else begin
            state <= next_state;
            case (state)
                WR_LEN: begin
                    len       <= ct_rddata;
                    i         <= '0;
                    j         <= '0;
                    k         <= 9'd1;
                    printable <= 1'b1;
                end
                RD_SI: begin
                    i <= i + 8'd1;
                end
                RD_SJ: begin
                    si <= s_rddata;
                    ct <= ct_rddata;
                    j  <= j + s_rddata;
                end
                WR_SI: begin
                    sj <= s_rddata;
                end
                WR_PT: begin
                    if ((pt_byte < PRINT_LO) || (pt_byte > PRINT_HI)) begin
                        printable <= 1'b0;
                    end
                    if (!last_byte) begin
                        k <= k + 9'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state decode and memory port drive; every output defaults to idle.
    always_comb begin
        next_state = state;
        s_addr     = '0;
        s_wrdata   = '0;
        s_wren     = 1'b0;
        ct_addr    = '0;
        pt_addr    = '0;
        pt_wrdata  = '0;
        pt_wren    = 1'b0;
        case (state)
            IDLE: begin
                if (en) begin
                    next_state = RD_LEN;
                end
            end
            RD_LEN: begin
                next_state = WT_LEN;
            end
            WT_LEN: begin
                next_state = WR_LEN;
            end
            WR_LEN: begin
                pt_addr    = 8'd0;
                pt_wrdata  = ct_rddata;
                pt_wren    = 1'b1;
                next_state = (ct_rddata == 8'd0) ? IDLE : RD_SI;
            end
            RD_SI: begin
                s_addr     = i + 8'd1;
                ct_addr    = k[7:0];
                next_state = WT_SI;
            end
            WT_SI: begin
                s_addr     = i;
                ct_addr    = k[7:0];
                next_state = RD_SJ;
            end
            RD_SJ: begin
                s_addr     = j + s_rddata;
                ct_addr    = k[7:0];
                next_state = WT_SJ;
            end
            WT_SJ: begin
                s_addr     = j;
                next_state = WR_SI;
            end
            WR_SI: begin
                s_addr     = i;
                s_wrdata   = s_rddata;
                s_wren     = 1'b1;
                next_state = WR_SJ;
            end
            WR_SJ: begin
                s_addr     = j;
                s_wrdata   = si;
                s_wren     = 1'b1;
                next_state = RD_PAD;
            end
            RD_PAD: begin
                s_addr     = si + sj;
                next_state = WT_PAD;
            end
            WT_PAD: begin
                s_addr     = si + sj;
                next_state = WR_PT;
            end
            WR_PT: begin
                pt_addr    = k[7:0];
                pt_wrdata  = pt_byte;
                pt_wren    = 1'b1;
                next_state = last_byte ? IDLE : RD_SI;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_prga_decrypt.sv
// Scoreboard bench for prga_decrypt: stimulus pushes expected PT writes and a
// completion record; a negedge monitor pops and compares as the DUT produces them.
module tb_prga_decrypt;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       rdy;
    logic       printable;
    logic [7:0] s_addr;
    logic [7:0] s_rddata;
    logic [7:0] s_wrdata;
    logic       s_wren;
    logic [7:0] ct_addr;
    logic [7:0] ct_rddata;
    logic [7:0] pt_addr;
    logic [7:0] pt_wrdata;
    logic       pt_wren;

    prga_decrypt dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .rdy       (rdy),
        .printable (printable),
        .s_addr    (s_addr),
        .s_rddata  (s_rddata),
        .s_wrdata  (s_wrdata),
        .s_wren    (s_wren),
        .ct_addr   (ct_addr),
        .ct_rddata (ct_rddata),
        .pt_addr   (pt_addr),
        .pt_wrdata (pt_wrdata),
        .pt_wren   (pt_wren)
    );

    always #5 clk = ~clk;

    logic [7:0] s_mem   [256];
    logic [7:0] ct_mem  [256];
    logic [7:0] pt_mem  [256];
    logic [7:0] model_s [256];
    logic [7:0] exp_tab [256];

    // Synchronous read-first memories with one cycle of read latency.
    always @(posedge clk) begin
        s_rddata  <= s_mem[s_addr];
        ct_rddata <= ct_mem[ct_addr];
        if (s_wren)  s_mem[s_addr]   <= s_wrdata;
        if (pt_wren) pt_mem[pt_addr] <= pt_wrdata;
    end

    typedef struct {
        bit         done;
        logic [7:0] addr;
        logic [7:0] data;
        bit         prt;
        int         lat;
        int         swr;
    } exp_t;

    exp_t sb[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int start_cyc = 0;
    int swr_cnt = 0;
    int overlap = 0;
    bit mute = 1'b0;
    bit prev_rdy = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Monitor: compares each PT write and each completion against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (s_wren) swr_cnt++;
        if (s_wren && pt_wren) overlap++;
        if (!mute) begin
            if (pt_wren) begin
                if (sb.size() == 0 || sb[0].done) begin
                    check("pt_unexpected_write", {24'd0, pt_addr}, 32'hFFFF);
                end else begin
                    e = sb.pop_front();
                    check($sformatf("pt_addr[%0d]", e.addr), {24'd0, pt_addr}, {24'd0, e.addr});
                    check($sformatf("pt_data[%0d]", e.addr), {24'd0, pt_wrdata}, {24'd0, e.data});
                end
            end
            if (rdy && !prev_rdy) begin
                if (sb.size() == 0 || !sb[0].done) begin
                    check("early_done", {31'd0, rdy}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("printable", {31'd0, printable}, {31'd0, e.prt});
                    check("latency", cyc - start_cyc, e.lat);
                    check("s_wren_count", swr_cnt, e.swr);
                    check("wren_overlap", overlap, 0);
                end
            end
        end
        prev_rdy = rdy;
    end

    // Standard ARC4 key scheduling on a 3-byte key into the S memory.
    task automatic load_ksa(input logic [7:0] k0, input logic [7:0] k1, input logic [7:0] k2);
        logic [7:0] key [3];
        logic [7:0] j;
        logic [7:0] t;
        key[0] = k0; key[1] = k1; key[2] = k2;
        for (int n = 0; n < 256; n++) s_mem[n] = 8'(n);
        j = 8'd0;
        for (int n = 0; n < 256; n++) begin
            j = j + s_mem[n] + key[n % 3];
            t = s_mem[n];
            s_mem[n] = s_mem[j];
            s_mem[j] = t;
        end
    endtask

    task automatic load_golden_ct();
        logic [7:0] ct [10];
        logic [7:0] pt [10];
        ct = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
        pt = '{8'h09, 8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
        for (int n = 0; n < 10; n++) begin
            ct_mem[n]  = ct[n];
            exp_tab[n] = pt[n];
        end
    endtask

    // Pushes expectations, then starts the DUT. mode 0 single pulse, 1 held, 2 pulsed.
    task automatic applyStimulus(input int mode, input bit use_tab);
        logic [7:0] len, i, j, si, sj, t, p;
        bit prt;
        exp_t e;
        len = ct_mem[0];
        for (int n = 0; n < 256; n++) model_s[n] = s_mem[n];
        i = 8'd0; j = 8'd0; prt = 1'b1;
        e = '{done: 1'b0, addr: 8'd0, data: len, prt: 1'b0, lat: 0, swr: 0};
        sb.push_back(e);
        for (int k = 1; k <= int'(len); k++) begin
            i = i + 8'd1;
            si = model_s[i];
            j = j + si;
            sj = model_s[j];
            model_s[i] = sj;
            model_s[j] = si;
            t = si + sj;
            p = ct_mem[k] ^ model_s[t];
            if (use_tab) p = exp_tab[k];
            if (p < 8'h20 || p > 8'h7E) prt = 1'b0;
            e = '{done: 1'b0, addr: 8'(k), data: p, prt: 1'b0, lat: 0, swr: 0};
            sb.push_back(e);
        end
        e = '{done: 1'b1, addr: 8'd0, data: 8'd0, prt: prt, lat: 4 + 9 * int'(len), swr: 2 * int'(len)};
        sb.push_back(e);
        @(negedge clk);
        swr_cnt = 0;
        overlap = 0;
        start_cyc = cyc;
        en = 1'b1;
        @(negedge clk);
        if (mode == 1) begin
            repeat (20) @(negedge clk);
        end else if (mode == 2) begin
            for (int n = 0; n < 10; n++) begin
                en = 1'b0;
                @(negedge clk);
                en = 1'b1;
                @(negedge clk);
            end
        end
        en = 1'b0;
    endtask

    // Waits for the scoreboard to drain within a cycle budget.
    task automatic checkOutput(input int budget, input string name);
        for (int n = 0; n < budget; n++) begin
            @(posedge clk);
            #1;
            if (sb.size() == 0) return;
        end
        check({name, "_timeout"}, sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        for (int n = 0; n < 256; n++) begin
            s_mem[n] = 8'(n); ct_mem[n] = 8'd0; pt_mem[n] = 8'd0; exp_tab[n] = 8'd0;
        end
        #1;
        check("reset_rdy", {31'd0, rdy}, 32'd1);
        check("reset_printable", {31'd0, printable}, 32'd0);
        check("reset_s_wren", {31'd0, s_wren}, 32'd0);
        check("reset_pt_wren", {31'd0, pt_wren}, 32'd0);
        check("reset_s_addr", {24'd0, s_addr}, 32'd0);
        check("reset_ct_addr", {24'd0, ct_addr}, 32'd0);
        check("reset_pt_addr", {24'd0, pt_addr}, 32'd0);
        check("reset_s_wrdata", {24'd0, s_wrdata}, 32'd0);
        check("reset_pt_wrdata", {24'd0, pt_wrdata}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        $display("[TB] golden vector, key \"Key\"");
        load_ksa(8'h4B, 8'h65, 8'h79);
        load_golden_ct();
        applyStimulus(0, 1'b1);
        checkOutput(200, "golden");

        $display("[TB] zero-length message");
        ct_mem[0] = 8'h00;
        applyStimulus(0, 1'b0);
        checkOutput(50, "len0");

        // Identity S: i=1, j=S[1]=1, pad=S[1+1]=02, so 08^02=0A (non-printable).
        $display("[TB] non-printable message, identity S");
        for (int n = 0; n < 256; n++) s_mem[n] = 8'(n);
        ct_mem[0] = 8'h01; ct_mem[1] = 8'h08; exp_tab[1] = 8'h0A;
        applyStimulus(0, 1'b1);
        checkOutput(50, "nonprint");

        $display("[TB] golden vector with en held");
        load_ksa(8'h4B, 8'h65, 8'h79);
        load_golden_ct();
        applyStimulus(1, 1'b1);
        checkOutput(200, "golden_held");

        $display("[TB] golden vector with en pulsed");
        load_ksa(8'h4B, 8'h65, 8'h79);
        load_golden_ct();
        applyStimulus(2, 1'b1);
        checkOutput(200, "golden_pulsed");

        $display("[TB] reset during WR_SI");
        load_ksa(8'h4B, 8'h65, 8'h79);
        load_golden_ct();
        mute = 1'b1;
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        for (int n = 0; n < 50; n++) begin
            if (s_wren) break;
            @(negedge clk);
        end
        check("reached_wr_si", {31'd0, s_wren}, 32'd1);
        rst = 1'b1;
        #1;
        check("abort_rdy", {31'd0, rdy}, 32'd1);
        check("abort_s_wren", {31'd0, s_wren}, 32'd0);
        @(negedge clk);
        check("abort_rdy_next", {31'd0, rdy}, 32'd1);
        check("abort_printable", {31'd0, printable}, 32'd0);
        check("abort_pt_wren", {31'd0, pt_wren}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        #1;
        mute = 1'b0;

        $display("[TB] fresh start after abort");
        for (int n = 0; n < 256; n++) s_mem[n] = 8'(n);
        ct_mem[0] = 8'h01; ct_mem[1] = 8'h08; exp_tab[1] = 8'h0A;
        applyStimulus(0, 1'b1);
        checkOutput(50, "after_abort");

        $display("[TB] 255-byte message against reference model");
        load_ksa(8'h0A, 8'h1B, 8'h2C);
        ct_mem[0] = 8'hFF;
        for (int n = 1; n < 256; n++) ct_mem[n] = 8'($urandom_range(0, 255));
        applyStimulus(0, 1'b0);
        checkOutput(2400, "len255");
        for (int n = 0; n < 256; n++) begin
            check($sformatf("final_S[%0d]", n), {24'd0, s_mem[n]}, {24'd0, model_s[n]});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
